// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// The counter width covers the largest timeout (2^24-1 cycles), and a
// helper turns a cycle count into the terminal value of the shared timer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_READY,
      GAP,
      RUN,
      FAULT
   } seq_state_t;

   localparam int CNT_W = 24;

   localparam int DEF_NUM_STAGES     = 3;
   localparam int DEF_HOLD_CYCLES    = 65535;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;

   // A phase lasting N cycles ends when the counter, started at zero, reads N-1.
   function automatic logic [CNT_W-1:0] cnt_limit(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Up-counter shared by the hold, gap and ready-timeout phases.
// Clear has priority over enable; hit flags equality with the current limit.
module seq_timer
   import reset_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);

   logic [CNT_W-1:0] count;

   // Count cycles of the active phase; restart from zero on every phase change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign hit = (count == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all subsystems in reset for a settle period,
// then releases them one at a time in index order, waiting for each stage's
// ready before a gap and the next release. A stage that never reports ready
// within the timeout puts every stage back in reset and latches a fault.
// All outputs are registered; soft_rst_req restarts from the hold phase.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          soft_rst_req,
   input  logic [NUM_STAGES-1:0]         stage_ready,
   output logic [NUM_STAGES-1:0]         stage_rst,
   output logic                          all_ready,
   output logic                          fault,
   output logic [$clog2(NUM_STAGES)-1:0] fault_stage,
   output logic                          busy
);

   localparam int               IDX_W    = $clog2(NUM_STAGES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = cnt_limit(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LIM  = cnt_limit(GAP_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LIM  = cnt_limit(TIMEOUT_CYCLES);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] next_idx;
   logic             cur_ready;
   logic             hit;
   logic             tmr_clr;
   logic             tmr_en;
   logic [CNT_W-1:0] tmr_limit;

   // Only the stage currently being waited on is looked at.
   assign cur_ready = stage_ready[idx];
   assign next_idx  = idx + IDX_W'(1);

   // Pick the timer limit for the current phase and clear it on every phase exit.
   always_comb begin
      tmr_limit = HOLD_LIM;
      tmr_en    = 1'b0;
      tmr_clr   = 1'b1;
      case (state)
         HOLD: begin
            tmr_limit = HOLD_LIM;
            tmr_en    = 1'b1;
            tmr_clr   = hit;
         end
         WAIT_READY: begin
            tmr_limit = TMO_LIM;
            tmr_en    = 1'b1;
            tmr_clr   = cur_ready | hit;
         end
         GAP: begin
            tmr_limit = GAP_LIM;
            tmr_en    = 1'b1;
            tmr_clr   = hit;
         end
         default: begin
            tmr_en = 1'b0;
         end
      endcase
      // A held restart request keeps the hold phase from ever expiring.
      if (soft_rst_req) begin
         tmr_clr = 1'b1;
      end
   end

   seq_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .limit (tmr_limit),
      .hit   (hit)
   );

   // Sequencer state and registered outputs; restart overrides every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HOLD;
         idx         <= '0;
         stage_rst   <= '1;
         all_ready   <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= '0;
         busy        <= 1'b1;
      end else if (soft_rst_req) begin
         state       <= HOLD;
         idx         <= '0;
         stage_rst   <= '1;
         all_ready   <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= '0;
         busy        <= 1'b1;
      end else begin
         case (state)
            HOLD: begin
               if (hit) begin
                  state        <= WAIT_READY;
                  stage_rst[0] <= 1'b0;
               end
            end
            WAIT_READY: begin
               // Ready wins over a timeout expiring on the same cycle.
               if (cur_ready) begin
                  if (idx == LAST_IDX) begin
                     state     <= RUN;
                     stage_rst <= '0;
                     all_ready <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end else if (hit) begin
                  state       <= FAULT;
                  fault       <= 1'b1;
                  fault_stage <= idx;
                  stage_rst   <= '1;
                  busy        <= 1'b0;
               end
            end
            GAP: begin
               if (hit) begin
                  state               <= WAIT_READY;
                  idx                 <= next_idx;
                  stage_rst[next_idx] <= 1'b0;
               end
            end
            RUN, FAULT: begin
               state <= state;
            end
            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal edge-exact
// expectations, then randomized ready/restart/reset activity, all checked
// every cycle against an event-time model of the release schedule.
module tb_reset_sequencer;

   localparam int NS   = 3;
   localparam int HOLD = 4;
   localparam int GAPC = 2;
   localparam int TMO  = 10;

   logic          clk;
   logic          rst_n;
   logic          soft_rst_req;
   logic [NS-1:0] stage_ready;
   logic [NS-1:0] stage_rst;
   logic          all_ready;
   logic          fault;
   logic [1:0]    fault_stage;
   logic          busy;

   reset_sequencer #(
      .NUM_STAGES     (NS),
      .HOLD_CYCLES    (HOLD),
      .GAP_CYCLES     (GAPC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst_req (soft_rst_req),
      .stage_ready  (stage_ready),
      .stage_rst    (stage_rst),
      .all_ready    (all_ready),
      .fault        (fault),
      .fault_stage  (fault_stage),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: absolute edge count since rst_n release, number of released
   // stages, and the edge at which the next release / timeout is due.
   int ec        = 0;
   int released  = 0;
   int t_release = HOLD;
   int t_wait    = 0;
   int fst       = 0;
   bit pending   = 1'b1;
   bit done      = 1'b0;
   bit faulted   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ec);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            ec        = 0;
            released  = 0;
            pending   = 1'b1;
            t_release = HOLD;
            done      = 1'b0;
            faulted   = 1'b0;
            fst       = 0;
         end else begin
            ec++;
            if (soft_rst_req) begin
               released  = 0;
               pending   = 1'b1;
               t_release = ec + HOLD;
               done      = 1'b0;
               faulted   = 1'b0;
            end else if (done || faulted) begin
               released = released;
            end else if (pending) begin
               if (ec == t_release) begin
                  released++;
                  pending = 1'b0;
                  t_wait  = ec;
               end
            end else if (stage_ready[released-1]) begin
               if (released == NS) begin
                  done = 1'b1;
               end else begin
                  pending   = 1'b1;
                  t_release = ec + GAPC;
               end
            end else if (ec == t_wait + TMO) begin
               faulted  = 1'b1;
               fst      = released - 1;
               released = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      logic [NS-1:0] exp_rst;
      logic [NS-1:0] ones;
      ones = '1;
      forever begin
         @(negedge clk);
         exp_rst = faulted ? ones : NS'(ones << released);
         chk("stage_rst", 32'(stage_rst), 32'(exp_rst));
         chk("all_ready", 32'(all_ready), 32'(done));
         chk("fault", 32'(fault), 32'(faulted));
         chk("busy", 32'(busy), 32'(!done && !faulted));
         if (faulted) chk("fault_stage", 32'(fault_stage), 32'(fst));
      end
   end

   task automatic goto(input int e);
      int guard;
      guard = 0;
      while (ec < e && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (ec < e) begin
         miscompares++;
         $display("FAIL goto_timeout: at edge %0d, wanted edge %0d", ec, e);
      end
   endtask

   task automatic pulse_soft(output int s);
      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      s = ec;
   endtask

   initial begin
      int s;
      int r;
      rst_n        = 1'b1;
      soft_rst_req = 1'b0;
      stage_ready  = 3'b111;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_stage_rst", 32'(stage_rst), 32'h7);
      chk("rst_all_ready", 32'(all_ready), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_fault_stage", 32'(fault_stage), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);
      rst_n = 1'b1;

      // 1: all ready, straight-through sequence
      goto(3);  chk("t1_e3", 32'(stage_rst), 32'h7);
      goto(4);  chk("t1_e4", 32'(stage_rst), 32'h6);
      goto(7);  chk("t1_e7", 32'(stage_rst), 32'h4);
      goto(10); chk("t1_e10", 32'(stage_rst), 32'h0);
      chk("t1_e10_ar", 32'(all_ready), 32'h0);
      goto(11); chk("t1_e11_ar", 32'(all_ready), 32'h1);
      chk("t1_e11_busy", 32'(busy), 32'h0);

      // 2: stage 1 ready arrives 5 cycles after its release
      stage_ready = 3'b101;
      pulse_soft(s);
      goto(s + 7);  chk("t2_rel1", 32'(stage_rst), 32'h4);
      goto(s + 11); stage_ready = 3'b111;
      goto(s + 13); chk("t2_gap", 32'(stage_rst), 32'h4);
      goto(s + 14); chk("t2_rel2", 32'(stage_rst), 32'h0);
      chk("t2_fault", 32'(fault), 32'h0);

      // 3: stage 1 never ready -> timeout
      stage_ready = 3'b101;
      pulse_soft(s);
      goto(s + 16); chk("t3_pre", 32'(fault), 32'h0);
      goto(s + 17); chk("t3_fault", 32'(fault), 32'h1);
      chk("t3_fstage", 32'(fault_stage), 32'h1);
      chk("t3_rst", 32'(stage_rst), 32'h7);
      chk("t3_busy", 32'(busy), 32'h0);
      goto(s + 67); chk("t3_hold", 32'(fault), 32'h1);
      chk("t3_hold_rst", 32'(stage_rst), 32'h7);

      // 4: restart out of FAULT
      stage_ready = 3'b111;
      pulse_soft(s);
      chk("t4_clr", 32'(fault), 32'h0);
      chk("t4_rst", 32'(stage_rst), 32'h7);
      goto(s + 3);  chk("t4_e3", 32'(stage_rst), 32'h7);
      goto(s + 4);  chk("t4_e4", 32'(stage_rst), 32'h6);
      goto(s + 10); chk("t4_e10", 32'(stage_rst), 32'h0);
      goto(s + 11); chk("t4_ar", 32'(all_ready), 32'h1);

      // 6: ready on the very edge the timeout would fire
      stage_ready = 3'b101;
      pulse_soft(s);
      goto(s + 16); chk("t6_pre", 32'(fault), 32'h0);
      stage_ready = 3'b111;
      goto(s + 17); chk("t6_nofault", 32'(fault), 32'h0);
      chk("t6_rst", 32'(stage_rst), 32'h4);
      goto(s + 19); chk("t6_rel2", 32'(stage_rst), 32'h0);
      goto(s + 20); chk("t6_ar", 32'(all_ready), 32'h1);

      // 5: asynchronous reset in the middle of a gap
      pulse_soft(s);
      goto(s + 8); chk("t5_pre", 32'(stage_rst), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_rst", 32'(stage_rst), 32'h7);
      chk("t5_async_ar", 32'(all_ready), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      goto(3);  chk("t5_e3", 32'(stage_rst), 32'h7);
      goto(4);  chk("t5_e4", 32'(stage_rst), 32'h6);
      goto(11); chk("t5_ar", 32'(all_ready), 32'h1);

      // Randomized ready / restart / reset activity
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         r = int'($urandom_range(0, 999));
         soft_rst_req = (r < 15);
         if ($urandom_range(0, 9) == 0) begin
            stage_ready[$urandom_range(0, NS - 1)] = ~stage_ready[$urandom_range(0, NS - 1)];
         end
         if ($urandom_range(0, 29) == 0) begin
            stage_ready = 3'($urandom_range(0, 7));
         end
         if (r == 999) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      soft_rst_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
